// File: rtl/seg7_if.sv
// Pin-side bundle for the multiplexed 7-segment scanner: display requests in,
// active-low LED drives out.
interface seg7_if #(
  parameter int DIGITS = 8
);
  logic                  freeze;
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank;
  logic [3:0]            bright;
  logic [DIGITS-1:0]     led_en;
  logic [6:0]            led_seg;
  logic                  led_dp;

  modport master (
    output freeze, load, data, dp_in, blank, bright,
    input  led_en, led_seg, led_dp
  );

  modport slave (
    input  freeze, load, data, dp_in, blank, bright,
    output led_en, led_seg, led_dp
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with shadowed data, PWM dimming and
// blanking. Define SEG7_LZS_EN to enable leading-zero suppression captured at load.
module seg7_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int SCAN_LOG2 = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  seg7_if.slave    bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SCAN_LOG2-1:0] prescaler_r;
  logic [IDX_W-1:0]     index_r;
  logic [4*DIGITS-1:0]  shadow_data_r;
  logic [DIGITS-1:0]    shadow_dp_r;
  logic [DIGITS-1:0]    shadow_blank_r;
  logic [DIGITS-1:0]    lzs_mask_s;
  logic [3:0]           nibble_s;
  logic [3:0]           phase_s;
  logic                 lit_s;
  logic [DIGITS-1:0]    en_s;
  logic [6:0]           seg_s;
  logic                 dp_s;
  logic [DIGITS-1:0]    led_en_r;
  logic [6:0]           led_seg_r;
  logic                 led_dp_r;

  // Hex nibble to active-high {g,f,e,d,c,b,a}.
  function automatic logic [6:0] encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

`ifdef SEG7_LZS_EN
  // A digit above 0 is suppressed while it and every higher nibble are zero and no dp is requested.
  function automatic logic [DIGITS-1:0] lzs_mask(input logic [4*DIGITS-1:0] dat,
                                                 input logic [DIGITS-1:0]   dpm);
    logic [DIGITS-1:0] mask;
    logic              zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (dat[4*i +: 4] != 4'h0) begin
        zero_above = 1'b0;
      end else begin
        zero_above = zero_above;
      end
      mask[i] = zero_above & ~dpm[i];
    end
    return mask;
  endfunction

  assign lzs_mask_s = lzs_mask(bus.data, bus.dp_in);
`else
  assign lzs_mask_s = '0;
`endif

  // Shadow capture; suppression is folded into the stored blank mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data_r  <= '0;
      shadow_dp_r    <= '0;
      shadow_blank_r <= '0;
    end else if (bus.load) begin
      shadow_data_r  <= bus.data;
      shadow_dp_r    <= bus.dp_in;
      shadow_blank_r <= bus.blank | lzs_mask_s;
    end
  end

  // Slot prescaler and digit index; freeze parks both at the start of digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_r <= '0;
      index_r     <= '0;
    end else if (bus.freeze) begin
      prescaler_r <= '0;
      index_r     <= '0;
    end else begin
      prescaler_r <= prescaler_r + {{(SCAN_LOG2-1){1'b0}}, 1'b1};
      if (prescaler_r == {SCAN_LOG2{1'b1}}) begin
        if (index_r == IDX_W'(DIGITS - 1)) begin
          index_r <= '0;
        end else begin
          index_r <= index_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Next pin state from the current scan position and shadow contents.
  always_comb begin
    nibble_s = shadow_data_r[{index_r, 2'b00} +: 4];
    phase_s  = prescaler_r[SCAN_LOG2-1 -: 4];
    lit_s    = !bus.freeze && (phase_s <= bus.bright) && !shadow_blank_r[index_r];
    en_s     = '1;
    seg_s    = 7'h7F;
    dp_s     = 1'b1;
    if (lit_s) begin
      en_s[index_r] = 1'b0;
      seg_s         = ~encode(nibble_s);
      dp_s          = ~shadow_dp_r[index_r];
    end else begin
      en_s  = '1;
      seg_s = 7'h7F;
      dp_s  = 1'b1;
    end
  end

  // Registered pin drivers; dark whenever the digit is not lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_en_r  <= '1;
      led_seg_r <= 7'h7F;
      led_dp_r  <= 1'b1;
    end else begin
      led_en_r  <= en_s;
      led_seg_r <= seg_s;
      led_dp_r  <= dp_s;
    end
  end

  assign bus.led_en  = led_en_r;
  assign bus.led_seg = led_seg_r;
  assign bus.led_dp  = led_dp_r;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGITS=8, SCAN_LOG2=4 (16-cycle slots).
module tb_seg7_scan_ctrl;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   chk_cnt;

  seg7_if #(.DIGITS(8)) bus ();

  seg7_scan_ctrl #(.DIGITS(8), .SCAN_LOG2(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] enc_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Expected {led_en, led_seg, led_dp} at the k-th edge after scanning starts at digit 0.
  function automatic logic [15:0] model(int k, logic [3:0] br, logic [31:0] dat,
                                        logic [7:0] blk, logic [7:0] dpm);
    int         d;
    int         ph;
    logic [7:0] m;
    logic [3:0] nib;
    logic [15:0] r;
    d  = (k / 16) % 8;
    ph = k % 16;
    m  = blk;
`ifdef SEG7_LZS_EN
    begin
      logic za;
      za = 1'b1;
      for (int i = 7; i >= 1; i--) begin
        if (dat[i*4 +: 4] != 4'h0) za = 1'b0;
        if (za && !dpm[i]) m[i] = 1'b1;
      end
    end
`endif
    nib = dat[d*4 +: 4];
    if (ph <= int'(br) && !m[d]) begin
      r[15:8] = ~(8'h01 << d);
      r[7:1]  = ~enc_tab[nib];
      r[0]    = ~dpm[d];
    end else begin
      r = 16'hFFFF;
    end
    return r;
  endfunction

  function automatic logic [15:0] obs();
    return {bus.led_en, bus.led_seg, bus.led_dp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load shadow while frozen so the next edge starts digit 0 with a full slot.
  task automatic sync_load(logic [31:0] dat, logic [7:0] dpm, logic [7:0] blk);
    bus.freeze = 1'b1;
    bus.load   = 1'b1;
    bus.data   = dat;
    bus.dp_in  = dpm;
    bus.blank  = blk;
    tick();
    bus.load   = 1'b0;
    bus.freeze = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.freeze = 1'b0;
    bus.load   = 1'b1;
    bus.data   = 32'hFFFF_FFFF;
    bus.dp_in  = 8'hFF;
    bus.blank  = 8'h00;
    bus.bright = 4'hF;
    tick();
    tick();
    chk_cnt++;
    if (bus.led_en !== 8'hFF) $display("FAIL reset_en got=%h exp=ff", bus.led_en);
    else pass_cnt++;
    chk_cnt++;
    if (bus.led_seg !== 7'h7F) $display("FAIL reset_seg got=%h exp=7f", bus.led_seg);
    else pass_cnt++;
    chk_cnt++;
    if (bus.led_dp !== 1'b1) $display("FAIL reset_dp got=%b exp=1", bus.led_dp);
    else pass_cnt++;
    bus.load = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_scan();
    logic [15:0] e;
    sync_load(32'h0123ABCD, 8'h00, 8'h00);
    for (int k = 0; k < 144; k++) begin
      tick();
      e = model(k, 4'hF, 32'h0123ABCD, 8'h00, 8'h00);
      chk_cnt++;
      if (obs() !== e) $display("FAIL scan k=%0d got=%h exp=%h", k, obs(), e);
      else pass_cnt++;
    end
  endtask

  task automatic test_brightness();
    logic [15:0] e;
    int          lit_cnt [2][8];
    logic [3:0]  brs [2] = '{4'd3, 4'd0};
    int          want [2] = '{4, 1};
    for (int b = 0; b < 2; b++) begin
      bus.bright = brs[b];
      sync_load(32'h0123ABCD, 8'h00, 8'h00);
      for (int d = 0; d < 8; d++) lit_cnt[b][d] = 0;
      for (int k = 0; k < 128; k++) begin
        tick();
        for (int d = 0; d < 8; d++) if (bus.led_en[d] === 1'b0) lit_cnt[b][d]++;
        e = model(k, brs[b], 32'h0123ABCD, 8'h00, 8'h00);
        chk_cnt++;
        if (obs() !== e) $display("FAIL bright%0d k=%0d got=%h exp=%h", brs[b], k, obs(), e);
        else pass_cnt++;
      end
      for (int d = 0; d < 8; d++) begin
        chk_cnt++;
        if (lit_cnt[b][d] != want[b])
          $display("FAIL bright%0d_duty d=%0d got=%0d exp=%0d", brs[b], d, lit_cnt[b][d], want[b]);
        else pass_cnt++;
      end
    end
    bus.bright = 4'hF;
  endtask

  task automatic test_shadow();
    logic [15:0] e;
    sync_load(32'h0123ABCD, 8'h00, 8'h00);
    for (int k = 0; k < 40; k++) begin
      tick();
      e = model(k, 4'hF, (k <= 20) ? 32'h0123ABCD : 32'hFFFF_FFFF, 8'h00, 8'h00);
      chk_cnt++;
      if (obs() !== e) $display("FAIL shadow k=%0d got=%h exp=%h", k, obs(), e);
      else pass_cnt++;
      if (k == 5) bus.data = 32'h5555_5555;
      if (k == 19) begin
        bus.data = 32'hFFFF_FFFF;
        bus.load = 1'b1;
      end
      if (k == 20) bus.load = 1'b0;
    end
  endtask

  task automatic test_blank_dp();
    logic [15:0] e;
    int          d1_lit;
    d1_lit = 0;
    sync_load(32'h0123ABCD, 8'h01, 8'h02);
    for (int k = 0; k < 48; k++) begin
      tick();
      if (bus.led_en[1] === 1'b0) d1_lit++;
      e = model(k, 4'hF, 32'h0123ABCD, 8'h02, 8'h01);
      chk_cnt++;
      if (obs() !== e) $display("FAIL blank_dp k=%0d got=%h exp=%h", k, obs(), e);
      else pass_cnt++;
    end
    chk_cnt++;
    if (d1_lit != 0) $display("FAIL blank_d1 got=%0d lit cycles exp=0", d1_lit);
    else pass_cnt++;
  endtask

  task automatic test_freeze();
    logic [15:0] e;
    sync_load(32'h0123ABCD, 8'h00, 8'h00);
    for (int k = 0; k < 84; k++) begin
      tick();
      e = model(k, 4'hF, 32'h0123ABCD, 8'h00, 8'h00);
      chk_cnt++;
      if (obs() !== e) $display("FAIL pre_freeze k=%0d got=%h exp=%h", k, obs(), e);
      else pass_cnt++;
    end
    bus.freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_cnt++;
      if (obs() !== 16'hFFFF) $display("FAIL freeze_off k=%0d got=%h exp=ffff", k, obs());
      else pass_cnt++;
    end
    bus.freeze = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      e = model(k, 4'hF, 32'h0123ABCD, 8'h00, 8'h00);
      chk_cnt++;
      if (obs() !== e) $display("FAIL unfreeze k=%0d got=%h exp=%h", k, obs(), e);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] e;
    sync_load(32'h0123ABCD, 8'h01, 8'h02);
    for (int k = 0; k < 6; k++) tick();
    chk_cnt++;
    if (obs() === 16'hFFFF) $display("FAIL pre_rst_lit got=%h exp=lit", obs());
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (obs() !== 16'hFFFF) $display("FAIL async_rst got=%h exp=ffff", obs());
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick();
      e = model(k, 4'hF, 32'h0, 8'h00, 8'h00);
      chk_cnt++;
      if (obs() !== e) $display("FAIL post_rst k=%0d got=%h exp=%h", k, obs(), e);
      else pass_cnt++;
    end
  endtask

`ifdef SEG7_LZS_EN
  task automatic test_lzs();
    logic [15:0] e;
    logic [31:0] dats [2] = '{32'h0000_0305, 32'h0000_0000};
    logic [7:0]  blks [2] = '{8'hF8, 8'hFE};
    for (int t = 0; t < 2; t++) begin
      sync_load(dats[t], 8'h00, 8'h00);
      for (int k = 0; k < 128; k++) begin
        tick();
        e = model(k, 4'hF, dats[t], blks[t], 8'h00);
        chk_cnt++;
        if (obs() !== e) $display("FAIL lzs%0d k=%0d got=%h exp=%h", t, k, obs(), e);
        else pass_cnt++;
      end
    end
  endtask
`endif

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    test_reset();
    test_scan();
    test_brightness();
    test_shadow();
    test_blank_dp();
    test_freeze();
    test_async_reset();
`ifdef SEG7_LZS_EN
    test_lzs();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
